// File: rtl/status_flags_pkg.sv
// Shared constants for the 6502 status-register stage: P bit positions,
// flag_op encodings, the reset value of P and a helper that assembles P.
package status_flags_pkg;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

    typedef enum logic [2:0] {
        FLAG_NONE = 3'd0,
        FLAG_C    = 3'd1,
        FLAG_I    = 3'd2,
        FLAG_D    = 3'd3,
        FLAG_V    = 3'd4
    } flag_op_e;

    // The six architectural flags; B and bit5 have no storage.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    function automatic logic [7:0] pack_p(input flags_t f, input logic brk);
        logic [7:0] p;
        p      = 8'h00;
        p[P_N] = f.n;
        p[P_V] = f.v;
        p[P_U] = 1'b1;
        p[P_B] = brk;
        p[P_D] = f.d;
        p[P_I] = f.i;
        p[P_Z] = f.z;
        p[P_C] = f.c;
        return p;
    endfunction

    function automatic flags_t unpack_p(input logic [7:0] p);
        flags_t f;
        f.n = p[P_N];
        f.v = p[P_V];
        f.d = p[P_D];
        f.i = p[P_I];
        f.z = p[P_Z];
        f.c = p[P_C];
        return f;
    endfunction

endpackage

// File: rtl/status_flags_if.sv
// Bundle of ALU results, control strobes and status outputs exchanged between
// the decode/ALU side (master) and the status-flag stage (slave).
interface status_flags_if;

    logic       RDY;
    logic [7:0] alu_out;
    logic       alu_CO;
    logic       alu_V;
    logic       alu_N;
    logic       alu_HC;
    logic [7:0] mem_in;
    logic       upd_nz;
    logic       upd_c;
    logic       upd_v;
    logic       adj_en;
    logic       adj_sub;
    logic       bit_op;
    logic       plp;
    logic [2:0] flag_op;
    logic       flag_val;
    logic       int_entry;
    logic       push_brk;

    logic [7:0] res;
    logic [7:0] P_push;
    logic       C;
    logic       Z;
    logic       I;
    logic       D;
    logic       V;
    logic       N;
    logic       BCD;
    logic       CI;

    modport master (
        output RDY, alu_out, alu_CO, alu_V, alu_N, alu_HC, mem_in,
               upd_nz, upd_c, upd_v, adj_en, adj_sub, bit_op, plp,
               flag_op, flag_val, int_entry, push_brk,
        input  res, P_push, C, Z, I, D, V, N, BCD, CI
    );

    modport slave (
        input  RDY, alu_out, alu_CO, alu_V, alu_N, alu_HC, mem_in,
               upd_nz, upd_c, upd_v, adj_en, adj_sub, bit_op, plp,
               flag_op, flag_val, int_entry, push_brk,
        output res, P_push, C, Z, I, D, V, N, BCD, CI
    );

endinterface

// File: rtl/status_flags_bcd_adjust.sv
// One-step decimal adjust of the binary ALU result (combinational).
// The correction amounts depend only on HC/CO as produced by the ALU.
module bcd_adjust (
    input  logic [7:0] i_alu_out,
    input  logic       i_alu_HC,
    input  logic       i_alu_CO,
    input  logic       i_adj,
    input  logic       i_adj_sub,
    output logic [7:0] o_adj_out
);

    logic       w_lo_fix;
    logic       w_hi_fix;
    logic [7:0] w_corr;

    // ADC corrects a nibble that carried; SBC corrects a nibble that borrowed
    // (carry flag low). The high correction is not re-evaluated after the low one.
    assign w_lo_fix = i_adj & (i_alu_HC ^ i_adj_sub);
    assign w_hi_fix = i_adj & (i_alu_CO ^ i_adj_sub);
    assign w_corr   = {1'b0, w_hi_fix, w_hi_fix, 1'b0, 1'b0, w_lo_fix, w_lo_fix, 1'b0};

    assign o_adj_out = i_adj_sub ? (i_alu_out - w_corr) : (i_alu_out + w_corr);

endmodule

// File: rtl/status_flags.sv
// 6502 processor status register P with decimal-adjusted result register.
// Resolves plp > interrupt entry > flag_op > datapath updates per flag.
module status_flags
    import status_flags_pkg::*;
#(
    parameter logic [7:0] RESET_P        = RESET_P_DEFAULT,
    parameter bit         CLEAR_D_ON_INT = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    status_flags_if.slave  bus
);

    flags_t     r_flags;
    flags_t     w_flags_next;
    logic [7:0] r_res;
    logic [7:0] w_adj_res;
    logic       w_adj;
    logic       w_wr_c;
    logic       w_wr_i;
    logic       w_wr_d;
    logic       w_wr_v;
    logic       w_unused;

    assign w_adj = bus.adj_en & r_flags.d;

    bcd_adjust u_bcd_adjust (
        .i_alu_out (bus.alu_out),
        .i_alu_HC  (bus.alu_HC),
        .i_alu_CO  (bus.alu_CO),
        .i_adj     (w_adj),
        .i_adj_sub (bus.adj_sub),
        .o_adj_out (w_adj_res)
    );

    always_comb begin
        w_flags_next = r_flags;
        w_wr_c       = 1'b0;
        w_wr_i       = 1'b0;
        w_wr_d       = 1'b0;
        w_wr_v       = 1'b0;

        if (bus.plp) begin
            w_flags_next = unpack_p(bus.mem_in);
        end else begin
            if (bus.int_entry) begin
                w_flags_next.i = 1'b1;
                w_wr_i         = 1'b1;
                if (CLEAR_D_ON_INT) begin
                    w_flags_next.d = 1'b0;
                    w_wr_d         = 1'b1;
                end
            end

            // w_wr_* mark flags already owned by a higher-priority source.
            case (flag_op_e'(bus.flag_op))
                FLAG_C: begin
                    w_flags_next.c = bus.flag_val;
                    w_wr_c         = 1'b1;
                end
                FLAG_I: begin
                    if (!w_wr_i) begin
                        w_flags_next.i = bus.flag_val;
                    end
                end
                FLAG_D: begin
                    if (!w_wr_d) begin
                        w_flags_next.d = bus.flag_val;
                    end
                end
                FLAG_V: begin
                    w_flags_next.v = 1'b0;
                    w_wr_v         = 1'b1;
                end
                default: begin
                end
            endcase

            if (bus.bit_op) begin
                w_flags_next.n = bus.mem_in[P_N];
                w_flags_next.z = (bus.alu_out == 8'h00);
                if (!w_wr_v) begin
                    w_flags_next.v = bus.mem_in[P_V];
                end
            end else begin
                if (bus.upd_nz) begin
                    w_flags_next.n = w_adj_res[7];
                    w_flags_next.z = (w_adj_res == 8'h00);
                end
                if (bus.upd_v && !w_wr_v) begin
                    w_flags_next.v = bus.alu_V;
                end
            end

            if (bus.upd_c && !w_wr_c) begin
                w_flags_next.c = bus.alu_CO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= unpack_p(RESET_P);
            r_res   <= 8'h00;
        end else if (bus.RDY) begin
            r_flags <= w_flags_next;
            r_res   <= w_adj_res;
        end
    end

    assign bus.res    = r_res;
    assign bus.P_push = pack_p(r_flags, bus.push_brk);
    assign bus.C      = r_flags.c;
    assign bus.Z      = r_flags.z;
    assign bus.I      = r_flags.i;
    assign bus.D      = r_flags.d;
    assign bus.V      = r_flags.v;
    assign bus.N      = r_flags.n;
    assign bus.BCD    = r_flags.d;
    assign bus.CI     = r_flags.c;

    // N comes from the adjusted result, and bit5/B are never stored.
    assign w_unused = ^{bus.alu_N, bus.mem_in[P_U], bus.mem_in[P_B]};

endmodule
